graph_pos_writeback: RTL

Write-side counterpart to graph_fetch. It takes one vertex address per job, consumes DIM position words from a valid/ready stream, and issues DIM sequential write requests to the graph position memory through a registered request port with backpressure. It sits between the force/position update pipeline and the memory write port. Updated positions land where graph_fetch reads them on the next iteration.

---
 rtl/graph_pos_writeback.sv | 123 ++++++++++++
 1 files changed

// File: rtl/graph_pos_writeback.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------+
// | graph_pos_writeback : one vertex job -> DIM sequential memory      |
// | writes from a valid/ready position stream.          Rev 1.0        |
// +-------------------------------------------------------------------+
module graph_pos_writeback #(
   parameter int                    DIM        = 4,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] POS_BASE   = '0
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [31:0]           v_addr_in,
   input  logic                  valid_in,
   output logic                  ready_out,
   input  logic [DATA_WIDTH-1:0] pos_data_in,
   input  logic                  pos_valid_in,
   output logic                  pos_ready_out,
   output logic [ADDR_WIDTH-1:0] mem_req_out,
   output logic [DATA_WIDTH-1:0] mem_wdata_out,
   output logic                  mem_valid_out,
   input  logic                  mem_ready_in,
   output logic                  done_out,
   output logic                  busy_out
);

   localparam int            KW     = (DIM > 1) ? $clog2(DIM) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(DIM - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                state;
   state_t                state_nx;
   logic [ADDR_WIDTH-1:0] base;
   logic [ADDR_WIDTH-1:0] job_base;
   logic [KW-1:0]         k;
   logic                  job_fire;
   logic                  pos_fire;
   logic                  mem_fire;
   logic                  last_word;

   // Vertex-to-address scaling wraps modulo 2^ADDR_WIDTH by construction.
   assign job_base  = POS_BASE + ADDR_WIDTH'(v_addr_in) * ADDR_WIDTH'(DIM);

   // done_out is registered, so IDLE keeps ready low for the pulse cycle.
   assign ready_out     = (state == IDLE) && !done_out;
   assign busy_out      = (state != IDLE);
   assign pos_ready_out = (state == WRITE) && (!mem_valid_out || mem_ready_in);

   assign job_fire  = valid_in && ready_out;
   assign pos_fire  = pos_valid_in && pos_ready_out;
   assign mem_fire  = mem_valid_out && mem_ready_in;
   assign last_word = (k == K_LAST);

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (job_fire) begin
               state_nx = WRITE;
            end
         end
         WRITE: begin
            if (pos_fire && last_word) begin
               state_nx = DRAIN;
            end
         end
         DRAIN: begin
            if (mem_fire) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         base          <= '0;
         k             <= '0;
         mem_req_out   <= '0;
         mem_wdata_out <= '0;
         mem_valid_out <= 1'b0;
         done_out      <= 1'b0;
      end else begin
         done_out <= 1'b0;
         if (job_fire) begin
            base <= job_base;
            k    <= '0;
         end
         // A refill takes priority: it overwrites a request leaving this cycle.
         if (pos_fire) begin
            mem_req_out   <= base + ADDR_WIDTH'(k);
            mem_wdata_out <= pos_data_in;
            mem_valid_out <= 1'b1;
            k             <= last_word ? '0 : k + 1'b1;
         end else if (mem_fire) begin
            mem_valid_out <= 1'b0;
            if (state == DRAIN) begin
               done_out <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire
